// File: rtl/adder_nway.sv
// adder_nway: N-bit two's-complement adder/subtractor built as a ripple-carry
// chain of per-bit full adders. Sum, carry, signed overflow and zero flags are
// registered together, giving one cycle from operands to result.
//
// Interface timing: there is no valid/ready handshake and no enable. The x, y
// and sub values present at each rising clk edge are captured unconditionally,
// so a new operation is accepted every cycle and its result is visible on
// s/c/o/z right after that edge.
module adder_nway #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sub,
  output logic [N-1:0] s,
  output logic         c,
  output logic         o,
  output logic         z
);

  // Subtraction reuses the adder chain as x + ~y + 1: operand B is inverted
  // and the chain's carry-in is driven by sub.
  logic [N-1:0] yb;
  logic [N:0]   k;
  logic [N-1:0] sum;
  logic         c_next;
  logic         o_next;
  logic         z_next;

  // Ripple-carry chain: each iteration is one full adder fed by the previous carry.
  always_comb begin
    yb   = sub ? ~y : y;
    k    = '0;
    sum  = '0;
    k[0] = sub;
    for (int i = 0; i < N; i++) begin
      sum[i]   = x[i] ^ yb[i] ^ k[i];
      k[i+1]   = (x[i] & yb[i]) | (k[i] & (x[i] ^ yb[i]));
    end
  end

  // Flags: carry out of the top bit (for sub, 1 means no borrow), signed
  // overflow when the carries into and out of the sign bit disagree, zero
  // when every result bit is clear.
  always_comb begin
    c_next = k[N];
    o_next = k[N] ^ k[N-1];
    z_next = ~|sum;
  end

  // Result register: the asynchronous reset discards any in-flight result
  // and presents a zero result (z = 1) until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0;
      c <= 1'b0;
      o <= 1'b0;
      z <= 1'b1;
    end else begin
      s <= sum;
      c <= c_next;
      o <= o_next;
      z <= z_next;
    end
  end

endmodule

// File: tb/tb_adder_nway.sv
// tb_adder_nway: self-checking bench for adder_nway (N = 4). Expected results
// come from plain integer arithmetic on the signed/unsigned operand values.
module tb_adder_nway;

  localparam int N = 4;
  localparam int W = N + 3;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] x = '0;
  logic [N-1:0] y = '0;
  logic         sub = 1'b0;
  logic [N-1:0] s;
  logic         c;
  logic         o;
  logic         z;

  always #5 clk = ~clk;

  adder_nway #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (x),
    .y     (y),
    .sub   (sub),
    .s     (s),
    .c     (c),
    .o     (o),
    .z     (z)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: returns {s, c, o, z}.
  function automatic logic [W-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic sb);
    int sa, sbv, ua, ub, r;
    logic [N-1:0] rs;
    logic cc, oo;
    sa  = $signed(a);
    sbv = $signed(b);
    ua  = a;
    ub  = b;
    r   = sb ? (sa - sbv) : (sa + sbv);
    rs  = r[N-1:0];
    cc  = sb ? (ua >= ub) : ((ua + ub) >= (1 << N));
    oo  = (r > ((1 << (N-1)) - 1)) || (r < -(1 << (N-1)));
    return {rs, cc, oo, (rs == '0)};
  endfunction

  // ---------------- driver ----------------
  task automatic op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sb,
                    input string tag);
    @(negedge clk);
    x   = a;
    y   = b;
    sub = sb;
    exp_q.push_back(model(a, b, sb));
    @(posedge clk);
    #1;
    check(tag, {s, c, o, z}, exp_q.pop_front());
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Reset held with operands present and clock running.
    rst_n = 1'b0;
    x = 4'd3;
    y = 4'd2;
    sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", {s, c, o, z}, {4'h0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release_3+2", {s, c, o, z}, {4'h5, 1'b0, 1'b0, 1'b0});

    // Spot checks against hand-derived constants.
    op(4'd7, 4'd1, 1'b0, "7+1");
    check("7+1_const", {s, c, o, z}, {4'h8, 1'b0, 1'b1, 1'b0});
    op(4'hF, 4'd1, 1'b0, "-1+1");
    check("-1+1_const", {s, c, o, z}, {4'h0, 1'b1, 1'b0, 1'b1});
    op(4'h8, 4'h8, 1'b0, "-8+-8");
    check("-8+-8_const", {s, c, o, z}, {4'h0, 1'b1, 1'b1, 1'b1});
    op(4'h8, 4'd7, 1'b0, "-8+7");
    check("-8+7_const", {s, c, o, z}, {4'hF, 1'b0, 1'b0, 1'b0});
    op(4'd5, 4'd3, 1'b1, "5-3");
    check("5-3_const", {s, c, o, z}, {4'h2, 1'b1, 1'b0, 1'b0});
    op(4'd3, 4'd5, 1'b1, "3-5");
    check("3-5_const", {s, c, o, z}, {4'hE, 1'b0, 1'b0, 1'b0});
    op(4'h8, 4'd1, 1'b1, "-8-1");
    check("-8-1_const", {s, c, o, z}, {4'h7, 1'b1, 1'b1, 1'b0});
    op(4'd7, 4'hF, 1'b1, "7-(-1)");
    check("7-(-1)_const", {s, c, o, z}, {4'h8, 1'b0, 1'b1, 1'b0});
    op(4'd4, 4'd4, 1'b1, "4-4");
    check("4-4_const", {s, c, o, z}, {4'h0, 1'b1, 1'b0, 1'b1});

    // Exhaustive add and subtract.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        op(i[N-1:0], j[N-1:0], 1'b0, "exh_add");
        op(i[N-1:0], j[N-1:0], 1'b1, "exh_sub");
      end
    end

    // Back-to-back operations in consecutive cycles.
    op(4'd2, 4'd2, 1'b0, "b2b_2+2");
    check("b2b_s0", {28'd0, s}, 32'd4);
    op(4'd7, 4'd1, 1'b0, "b2b_7+1");
    check("b2b_s1", {28'd0, s}, 32'd8);
    op(4'h8, 4'h8, 1'b0, "b2b_-8-8");
    check("b2b_s2", {28'd0, s}, 32'd0);

    // sub toggled mid-cycle: only the value at the edge counts.
    @(negedge clk);
    x = 4'd5;
    y = 4'd3;
    sub = 1'b1;
    #2;
    sub = 1'b0;
    @(posedge clk);
    #1;
    check("sub_midcycle", {s, c, o, z}, model(4'd5, 4'd3, 1'b0));

    // Asynchronous reset pulse between edges while s = 8.
    op(4'd7, 4'd1, 1'b0, "pre_async_7+1");
    check("pre_async_s", {28'd0, s}, 32'd8);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", {s, c, o, z}, {4'h0, 1'b0, 1'b0, 1'b1});
    rst_n = 1'b1;

    // Randomized operations.
    for (int n = 0; n < 300; n++) begin
      op(N'($urandom_range(0, (1 << N) - 1)), N'($urandom_range(0, (1 << N) - 1)),
         1'($urandom_range(0, 1)), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
